// File: rtl/dm_port_ctrl.sv
// Data-memory port controller: turns a MEM-stage load/store request into one
// SRAM transaction with big-endian byte enables, stalls the pipeline until the
// access completes, and abandons the access if the SRAM never acknowledges.
module dm_port_ctrl #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_WORD = 32'hBADDA7A0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       data_address_2DM,
  input  logic [31:0]       data_write_2DM,
  input  logic [1:0]        data_write_size_2DM,
  input  logic              MemRead_2DM,
  input  logic              MemWrite_2DM,
  output logic [31:0]       data_read_fDM,
  output logic              mem_stall,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_be,
  output logic [31:0]       sram_wdata,
  input  logic              sram_ack,
  input  logic [31:0]       sram_rdata,
  output logic              dm_timeout
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [WD_W-1:0] wd_q;
  logic [3:0]      be_d;
  logic            req_c;
  logic [1:0]      offset_c;
  logic [31:0]     addr_unused_c;

  // Address bits above the SRAM window and the byte offset are not part of
  // the word address; the offset only shapes the byte enables.
  assign addr_unused_c = data_address_2DM;
  assign offset_c      = data_address_2DM[1:0];
  assign req_c         = MemRead_2DM | MemWrite_2DM;

  // Big-endian byte enables: offset 0 is bits 31:24, i.e. sram_be[3].
  always_comb begin
    be_d = 4'b1111;
    if (MemWrite_2DM) begin
      case (data_write_size_2DM)
        2'd0: be_d = 4'b1111;
        2'd1: be_d = 4'b1000 >> offset_c;
        2'd2: be_d = offset_c[1] ? 4'b0011 : 4'b1100;
        2'd3: be_d = offset_c[0] ? 4'b0111 : 4'b1110;
        default: be_d = 4'b1111;
      endcase
    end
  end

  // Stall while a request is being accepted or is in flight; DONE releases it.
  assign mem_stall = RESET & (((state_q == S_IDLE) & req_c) | (state_q == S_BUSY));

  // Access sequencer with registered SRAM-side outputs and ack watchdog.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= S_IDLE;
      wd_q          <= '0;
      sram_req      <= 1'b0;
      sram_we       <= 1'b0;
      sram_addr     <= '0;
      sram_be       <= 4'b0000;
      sram_wdata    <= 32'd0;
      data_read_fDM <= 32'd0;
      dm_timeout    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_c) begin
            sram_addr  <= data_address_2DM[ADDR_W+1:2];
            sram_we    <= MemWrite_2DM;
            sram_be    <= be_d;
            sram_wdata <= data_write_2DM;
            sram_req   <= 1'b1;
            wd_q       <= '0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (sram_ack) begin
            sram_req <= 1'b0;
            wd_q     <= '0;
            if (!sram_we) data_read_fDM <= sram_rdata;
            state_q  <= S_DONE;
          end else if (wd_q == WD_LAST) begin
            sram_req   <= 1'b0;
            wd_q       <= '0;
            dm_timeout <= 1'b1;
            if (!sram_we) data_read_fDM <= ERR_WORD;
            state_q    <= S_DONE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_ctrl.sv
// Self-checking bench for dm_port_ctrl: directed cases plus randomized
// accesses checked against a byte-lane reference model.
module tb_dm_port_ctrl;

  localparam int unsigned ADDR_W   = 20;
  localparam int unsigned TIMEOUT  = 8;
  localparam logic [31:0] ERR_WORD = 32'hBADDA7A0;

  logic              CLK;
  logic              RESET;
  logic [31:0]       data_address_2DM;
  logic [31:0]       data_write_2DM;
  logic [1:0]        data_write_size_2DM;
  logic              MemRead_2DM;
  logic              MemWrite_2DM;
  logic [31:0]       data_read_fDM;
  logic              mem_stall;
  logic              sram_req;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [3:0]        sram_be;
  logic [31:0]       sram_wdata;
  logic              sram_ack;
  logic [31:0]       sram_rdata;
  logic              dm_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: last word returned to MEM and sticky watchdog flag.
  logic [31:0] exp_rd;
  logic        exp_to;

  dm_port_ctrl #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT),
    .ERR_WORD(ERR_WORD)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .data_address_2DM   (data_address_2DM),
    .data_write_2DM     (data_write_2DM),
    .data_write_size_2DM(data_write_size_2DM),
    .MemRead_2DM        (MemRead_2DM),
    .MemWrite_2DM       (MemWrite_2DM),
    .data_read_fDM      (data_read_fDM),
    .mem_stall          (mem_stall),
    .sram_req           (sram_req),
    .sram_we            (sram_we),
    .sram_addr          (sram_addr),
    .sram_be            (sram_be),
    .sram_wdata         (sram_wdata),
    .sram_ack           (sram_ack),
    .sram_rdata         (sram_rdata),
    .dm_timeout         (dm_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte lanes touched by an access: lane 0 = bits 31:24 = sram_be[3].
  function automatic logic [3:0] model_be(input logic wr, input logic [1:0] sz,
                                          input logic [1:0] off);
    int nbytes;
    int first;
    logic [3:0] m;
    if (!wr) return 4'b1111;
    nbytes = (sz == 2'd0) ? 4 : int'(sz);
    case (nbytes)
      4:       first = 0;
      1:       first = int'(off);
      2:       first = (off < 2'd2) ? 0 : 2;
      default: first = int'(off) % 2;
    endcase
    m = 4'b0000;
    for (int l = first; l < first + nbytes; l++) m[3 - l] = 1'b1;
    return m;
  endfunction

  // One access from IDLE; ack arrives in BUSY cycle ack_at (>= TIMEOUT: never).
  // Entered and left just after a falling edge with the DUT in IDLE.
  task automatic access(input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic rd, input logic wr,
                        input int ack_at, input logic [31:0] rdv);
    logic acked;
    logic stray;
    data_address_2DM    = addr;
    data_write_2DM      = wd;
    data_write_size_2DM = sz;
    MemRead_2DM         = rd;
    MemWrite_2DM        = wr;
    #1 check("stall_accept", 32'(mem_stall), 32'd1);
    @(negedge CLK);
    MemRead_2DM         = 1'b0;
    MemWrite_2DM        = 1'b0;
    data_address_2DM    = $urandom;
    data_write_2DM      = $urandom;
    data_write_size_2DM = 2'($urandom_range(0, 3));
    #1;
    check("req_busy", 32'(sram_req), 32'd1);
    check("we", 32'(sram_we), 32'(wr));
    check("addr", 32'(sram_addr), 32'(ADDR_W'(addr >> 2)));
    check("be", 32'(sram_be), 32'(model_be(wr, sz, addr[1:0])));
    check("wdata", sram_wdata, wd);
    acked = 1'b0;
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      check("stall_busy", 32'(mem_stall), 32'd1);
      check("req_held", 32'(sram_req), 32'd1);
      if (k == ack_at) begin
        sram_ack   = 1'b1;
        sram_rdata = rdv;
        acked      = 1'b1;
      end else begin
        sram_rdata = $urandom;
      end
      @(negedge CLK);
      sram_ack = 1'b0;
      if (acked) break;
    end
    if (!wr) exp_rd = acked ? rdv : ERR_WORD;
    if (!acked) exp_to = 1'b1;
    // DONE: optionally throw a stray ack and a new request at it; both ignored.
    stray = 1'($urandom_range(0, 1));
    if (stray) begin
      sram_ack    = 1'b1;
      sram_rdata  = $urandom;
      MemRead_2DM = 1'b1;
    end
    #1;
    check("stall_done", 32'(mem_stall), 32'd0);
    check("req_done", 32'(sram_req), 32'd0);
    check("rdata", data_read_fDM, exp_rd);
    check("timeout", 32'(dm_timeout), 32'(exp_to));
    @(negedge CLK);
    sram_ack = 1'b0;
    #1 check("req_idle", 32'(sram_req), 32'd0);
    MemRead_2DM = 1'b0;
    #1;
    check("stall_idle", 32'(mem_stall), 32'd0);
    check("rdata_idle", data_read_fDM, exp_rd);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  r;
    RESET               = 1'b0;
    data_address_2DM    = 32'd0;
    data_write_2DM      = 32'd0;
    data_write_size_2DM = 2'd0;
    MemRead_2DM         = 1'b1;
    MemWrite_2DM        = 1'b0;
    sram_ack            = 1'b0;
    sram_rdata          = 32'd0;
    exp_rd              = 32'd0;
    exp_to              = 1'b0;

    // Reset state, with a request already pending at the port.
    #1;
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_req", 32'(sram_req), 32'd0);
    check("rst_we", 32'(sram_we), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_be", 32'(sram_be), 32'd0);
    check("rst_wdata", sram_wdata, 32'd0);
    check("rst_rdata", data_read_fDM, 32'd0);
    check("rst_timeout", 32'(dm_timeout), 32'd0);
    @(negedge CLK);
    RESET       = 1'b1;
    MemRead_2DM = 1'b0;
    #1 check("idle_no_req", 32'(mem_stall), 32'd0);

    // Read, ack in first BUSY cycle.
    access(32'h0000_1008, 32'd0, 2'd0, 1'b1, 1'b0, 0, 32'h1122_3344);
    check("addr_0x402", 32'(sram_addr), 32'h402);
    // Byte store at offset 2.
    access(32'h0000_0002, 32'hAABB_CCDD, 2'd1, 1'b0, 1'b1, 2, 32'hDEAD_BEEF);
    check("byte_be", 32'(sram_be), 32'b0010);
    // Enable sweep for half and three-byte stores.
    for (int s = 2; s <= 3; s++)
      for (int o = 0; o < 4; o++)
        access(32'h0000_0100 + 32'(o), $urandom, 2'(s), 1'b0, 1'b1,
               $urandom_range(0, 3), $urandom);
    // Ack on the last permitted BUSY cycle: no error.
    access(32'h0000_0040, 32'd0, 2'd0, 1'b1, 1'b0, int'(TIMEOUT) - 1, 32'h0BAD_F00D);
    // No ack at all: watchdog fires, error word returned, flag sticks.
    access(32'h0000_0044, 32'd0, 2'd0, 1'b1, 1'b0, int'(TIMEOUT), 32'd0);
    access(32'h0000_0048, 32'd0, 2'd0, 1'b1, 1'b0, 1, 32'h5555_AAAA);
    // Both strobes: treated as a write.
    access(32'h0000_0020, 32'h0102_0304, 2'd0, 1'b1, 1'b1, 0, 32'h7777_7777);

    // Randomized accesses, some timing out.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      r = 2'($urandom_range(1, 3));
      access(a, $urandom, 2'($urandom_range(0, 3)), r[0], r[1],
             $urandom_range(0, int'(TIMEOUT) + 1), $urandom);
    end

    // Reset in the middle of a read.
    data_address_2DM = 32'h0000_0300;
    MemRead_2DM      = 1'b1;
    @(negedge CLK);
    MemRead_2DM = 1'b0;
    #2 RESET = 1'b0;
    #1;
    check("midrst_req", 32'(sram_req), 32'd0);
    check("midrst_rdata", data_read_fDM, 32'd0);
    check("midrst_stall", 32'(mem_stall), 32'd0);
    check("midrst_timeout", 32'(dm_timeout), 32'd0);
    exp_rd = 32'd0;
    exp_to = 1'b0;
    @(negedge CLK);
    RESET      = 1'b1;
    sram_ack   = 1'b1;
    sram_rdata = 32'hFFFF_FFFF;
    @(negedge CLK);
    sram_ack = 1'b0;
    #1;
    check("stray_req", 32'(sram_req), 32'd0);
    check("stray_stall", 32'(mem_stall), 32'd0);
    check("stray_rdata", data_read_fDM, 32'd0);
    access(32'h0000_0abc, 32'd0, 2'd0, 1'b1, 1'b0, 1, 32'hCAFE_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_port_ctrl.md
Name: dm_port_ctrl

Overview:
- Data-memory port controller directly downstream of the MEM stage.
- Consumes the MEM stage's data-memory request (address, merged write word, write size, read/write strobes) and drives a single-ported, word-wide SRAM with variable ack latency.
- Returns the read word to MEM on data_read_fDM and stalls the pipeline until each access completes.
- Generates big-endian byte enables from write size and address offset, and runs an ack watchdog.

Parameters:
- ADDR_W, 20, SRAM word-address width; sram_addr = data_address_2DM[ADDR_W+1:2].
- TIMEOUT, 64, cycles in BUSY without sram_ack before the access is abandoned.
- ERR_WORD, 32'hBADDA7A0, value returned on data_read_fDM for a timed-out read.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- data_address_2DM  in  32  byte address from MEM.
- data_write_2DM  in  32  merged write word from MEM.
- data_write_size_2DM  in  2  0=word, 1=byte, 2=half, 3=three bytes.
- MemRead_2DM  in  1  read request.
- MemWrite_2DM  in  1  write request.
- data_read_fDM  out  32  registered read word to MEM.
- mem_stall  out  1  freeze pipeline while the access is pending.
- sram_req  out  1  SRAM request, registered.
- sram_we  out  1  1=write, registered.
- sram_addr  out  ADDR_W  word address, registered.
- sram_be  out  4  byte enables; be[i] covers bits [8i+7:8i], registered.
- sram_wdata  out  32  write data, registered.
- sram_ack  in  1  one-cycle completion pulse.
- sram_rdata  in  32  read data, valid with sram_ack.
- dm_timeout  out  1  sticky watchdog error flag.

Behaviour:
- Reset (async, RESET=0): state=IDLE, sram_req=0, sram_we=0, sram_addr=0, sram_be=0, sram_wdata=0, data_read_fDM=0, dm_timeout=0, watchdog=0. mem_stall is forced 0 while RESET=0. Reset mid-access drops sram_req immediately and abandons the access; a late sram_ack arriving in IDLE is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req = MemRead_2DM | MemWrite_2DM. If req: mem_stall=1 (combinational).
  - Latch sram_addr, sram_we=MemWrite_2DM, sram_be, sram_wdata=data_write_2DM; set sram_req=1; go to BUSY.
  - If both strobes are high, the access is a write.
  - If req is low: mem_stall=0 and the state stays IDLE.
- BUSY:
  - mem_stall=1 and sram_req=1. Address, enables and data are held stable; the watchdog increments each cycle.
  - On sram_ack: sram_req=0, watchdog clears, go to DONE. For a read, data_read_fDM <= sram_rdata. For a write, data_read_fDM is unchanged.
  - If the watchdog reaches TIMEOUT-1 with no ack: sram_req=0, dm_timeout<=1, go to DONE. For a read, data_read_fDM <= ERR_WORD.
  - Ack and timeout in the same cycle: ack wins, no error.
- DONE:
  - mem_stall=0 for exactly one cycle so the pipeline advances; go to IDLE. No new request is accepted in DONE.
  - Minimum latency: 3 cycles per access (IDLE, BUSY with ack, DONE).
- Byte enables for reads are 4'b1111.
- Byte enables for writes, big-endian, with offset = address[1:0] and lane 0 = bits 31:24:
  - size 0 -> 1111.
  - size 1 -> 1000 >> offset.
  - size 2 -> offset 0,1 -> 1100; offset 2,3 -> 0011.
  - size 3 -> offset 0,2 -> 1110; offset 1,3 -> 0111.
- dm_timeout clears only on reset.
- sram_ack outside BUSY is ignored.

Test Plan:
- Read with ack 1 cycle after req: addr 0x0000_1008, sram_rdata 0x11223344 -> sram_addr=0x402, sram_be=1111, data_read_fDM=0x11223344 after ack, mem_stall high for exactly 2 cycles.
- Byte store: size 1, addr 0x...0002, data 0xAABBCCDD -> sram_we=1, sram_be=0010, sram_wdata=0xAABBCCDD, data_read_fDM unchanged.
- Enable sweep: size 2 at offsets 0..3 -> 1100,1100,0011,0011; size 3 at offsets 0..3 -> 1110,0111,1110,0111.
- Watchdog: TIMEOUT=8, read, no ack -> sram_req drops after 8 BUSY cycles, dm_timeout=1 (sticky), data_read_fDM=0xBADDA7A0. Ack on the 8th BUSY cycle -> no error.
- Both strobes high, addr 0x20 -> write performed, sram_we=1. Back-to-back requests -> one DONE cycle with mem_stall=0 between accesses.
- RESET low while in BUSY -> sram_req=0 immediately, data_read_fDM=0. Stray sram_ack after release -> ignored, state IDLE.
